// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite engine: lifecycle states, heading codes, body palette.
package sprite_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    BURST,
    RESPAWN,
    GUARD
  } life_state_t;

  localparam logic [2:0] ORIENT_N      = 3'd0;
  localparam logic [2:0] ORIENT_E      = 3'd2;
  localparam logic [2:0] ORIENT_S      = 3'd4;
  localparam logic [2:0] ORIENT_W      = 3'd6;
  // Diagonal headings fold onto the cardinal below them.
  localparam logic [2:0] CARDINAL_MASK = 3'b110;

  localparam logic [11:0] PALETTE [4] = '{12'hFFF, 12'h000, 12'h00F, 12'h025};

  function automatic logic [11:0] palette_lookup(input logic [1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite ROM bus: one shared address to the body and explosion ROMs, each with 1-cycle read data.
interface sprite_engine_if #(
  parameter int ICON_LOG2 = 5,
  parameter int COLOR_W   = 12
);
  logic [2*ICON_LOG2-1:0] tank_addr;
  logic [2*ICON_LOG2-1:0] boom_addr;
  logic [1:0]             tank_data;
  logic [COLOR_W-1:0]     boom_data;

  modport master (output tank_addr, output boom_addr, input tank_data, input boom_data);
  modport slave  (input tank_addr, input boom_addr, output tank_data, output boom_data);
endinterface

// File: rtl/sprite_lifecycle_fsm.sv
// Hit -> burst -> respawn -> guard lifecycle with a shared 32-bit phase counter.
// With SPRITE_BLINK_EN defined, blink pulses during GUARD from counter bit 22.
module sprite_lifecycle_fsm
  import sprite_pkg::*;
#(
  parameter logic [31:0] BURST_CYCLES   = 32'h2FFFFFF,
  parameter logic [31:0] RESPAWN_CYCLES = 32'd16,
  parameter logic [31:0] GUARD_CYCLES   = 32'h1FFFFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  output logic burst,
  output logic tank_reset,
  output logic guarded,
  output logic blink
);

  life_state_t state, next_state;
  logic [31:0] count, next_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ALIVE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Each phase ends on its last counted cycle; any state change restarts the count.
  always_comb begin
    next_state = state;
    next_count = count + 32'd1;
    burst      = 1'b0;
    tank_reset = 1'b0;
    guarded    = 1'b0;
    case (state)
      ALIVE: begin
        next_count = '0;
        if (hit) next_state = BURST;
      end
      BURST: begin
        burst = 1'b1;
        if (count == BURST_CYCLES - 32'd1) next_state = RESPAWN;
      end
      RESPAWN: begin
        tank_reset = 1'b1;
        if (count == RESPAWN_CYCLES - 32'd1) next_state = GUARD;
      end
      GUARD: begin
        guarded = 1'b1;
        if (count == GUARD_CYCLES - 32'd1) next_state = ALIVE;
      end
      default: next_state = ALIVE;
    endcase
    if (next_state != state) next_count = '0;
  end

`ifdef SPRITE_BLINK_EN
  assign blink = guarded & count[22];
`else
  assign blink = 1'b0;
`endif

endmodule

// File: rtl/sprite_engine.sv
// Sprite renderer: window/rotation addressing, ROM-aligned colour pipeline and lifecycle control.
// SPRITE_BLINK_EN (handled in the lifecycle FSM) blanks the icon periodically while guarded.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int                 ICON_LOG2      = 5,
  parameter int                 COLOR_W        = 12,
  parameter int                 X_SHIFT        = 3,
  parameter int                 Y_MUL          = 6,
  parameter logic [31:0]        BURST_CYCLES   = 32'h2FFFFFF,
  parameter logic [31:0]        RESPAWN_CYCLES = 32'd16,
  parameter logic [31:0]        GUARD_CYCLES   = 32'h1FFFFFF,
  parameter logic [COLOR_W-1:0] TRANSPARENT    = COLOR_W'(12'hFFF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [11:0]         pixel_column,
  input  logic [11:0]         pixel_row,
  input  logic [7:0]          loc_x,
  input  logic [7:0]          loc_y,
  input  logic [2:0]          orient,
  input  logic                hit,
  sprite_engine_if.master     rom,
  output logic                icon,
  output logic [COLOR_W-1:0]  icon_c,
  output logic                burst,
  output logic                tank_reset,
  output logic                guarded
);

  localparam logic [12:0] SPAN = 13'((1 << ICON_LOG2) - 1);

  logic [11:0]            col0, row0;
  logic [12:0]            col_hi, row_hi;
  logic                   in_window;
  logic [ICON_LOG2-1:0]   dc, dr;
  logic [2*ICON_LOG2-1:0] addr;
  logic                   win_q, snap_q;
  logic [COLOR_W-1:0]     colour;
  logic                   blink;

  sprite_lifecycle_fsm #(
    .BURST_CYCLES   (BURST_CYCLES),
    .RESPAWN_CYCLES (RESPAWN_CYCLES),
    .GUARD_CYCLES   (GUARD_CYCLES)
  ) u_lifecycle (
    .clk        (clk),
    .reset      (reset),
    .hit        (hit),
    .burst      (burst),
    .tank_reset (tank_reset),
    .guarded    (guarded),
    .blink      (blink)
  );

  // Upper bounds use 13 bits so a sprite near the raster edge clips instead of wrapping.
  assign col0      = {4'b0, loc_x} << X_SHIFT;
  assign row0      = {4'b0, loc_y} * 12'(Y_MUL);
  assign col_hi    = {1'b0, col0} + SPAN;
  assign row_hi    = {1'b0, row0} + SPAN;
  assign in_window = (pixel_column >= col0) && ({1'b0, pixel_column} <= col_hi) &&
                     (pixel_row >= row0) && ({1'b0, pixel_row} <= row_hi);
  assign dc        = ICON_LOG2'(pixel_column - col0);
  assign dr        = ICON_LOG2'(pixel_row - row0);

  always_comb begin
    addr = {dr, dc};
    case (orient & CARDINAL_MASK)
      ORIENT_N: addr = {dr, dc};
      ORIENT_E: addr = {~dc, dr};
      ORIENT_S: addr = {~dr, ~dc};
      ORIENT_W: addr = {dc, ~dr};
      default:  addr = {dr, dc};
    endcase
  end

  // The ROMs register this address themselves, so the read lands alongside win_q/snap_q.
  assign rom.tank_addr = addr;
  assign rom.boom_addr = addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= 1'b0;
      snap_q <= 1'b0;
    end else begin
      win_q  <= in_window;
      snap_q <= burst;
    end
  end

  assign colour = snap_q ? rom.boom_data : COLOR_W'(palette_lookup(rom.tank_data));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icon   <= 1'b0;
      icon_c <= '0;
    end else begin
      icon   <= win_q && (colour != TRANSPARENT) && !blink;
      icon_c <= colour;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: randomized raster/heading stimulus against a reference model.
module tb_sprite_engine;

  localparam int ICON_LOG2 = 5;
  localparam int COLOR_W   = 12;
  localparam int X_SHIFT   = 3;
  localparam int Y_MUL     = 6;
  localparam int BURST_N   = 8;
  localparam int RESPAWN_N = 4;
  localparam int GUARD_N   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_column, pixel_row;
  logic [7:0]  loc_x, loc_y;
  logic [2:0]  orient;
  logic        hit;
  logic        icon;
  logic [11:0] icon_c;
  logic        burst, tank_reset, guarded;

  sprite_engine_if #(.ICON_LOG2(ICON_LOG2), .COLOR_W(COLOR_W)) rom ();

  sprite_engine #(
    .ICON_LOG2      (ICON_LOG2),
    .COLOR_W        (COLOR_W),
    .X_SHIFT        (X_SHIFT),
    .Y_MUL          (Y_MUL),
    .BURST_CYCLES   (32'd8),
    .RESPAWN_CYCLES (32'd4),
    .GUARD_CYCLES   (32'd6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .loc_x        (loc_x),
    .loc_y        (loc_y),
    .orient       (orient),
    .hit          (hit),
    .rom          (rom),
    .icon         (icon),
    .icon_c       (icon_c),
    .burst        (burst),
    .tank_reset   (tank_reset),
    .guarded      (guarded)
  );

  always #5 clk = ~clk;

  logic [1:0]  tank_rom [1024];
  logic [11:0] boom_rom [1024];

  always @(posedge clk) begin
    rom.tank_data <= tank_rom[rom.tank_addr];
    rom.boom_data <= boom_rom[rom.boom_addr];
  end

  int compared   = 0;
  int mismatched = 0;
  int palette [4] = '{32'hFFF, 32'h000, 32'h00F, 32'h025};

  // Lifecycle model: phase 0 alive, 1 burst, 2 respawn, 3 guard; left = cycles remaining.
  int phase = 0;
  int left  = 0;

  logic        e1_valid = 1'b0, e2_valid = 1'b0;
  logic        e1_icon, e2_icon;
  logic [11:0] e1_col, e2_col;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int origin_col(input int lx);
    return (lx * (1 << X_SHIFT)) % 4096;
  endfunction

  function automatic int origin_row(input int ly);
    return (ly * Y_MUL) % 4096;
  endfunction

  function automatic int ref_addr(input int c, input int r, input int lx, input int ly, input int o);
    int dc, dr;
    dc = (((c - origin_col(lx)) % 32) + 32) % 32;
    dr = (((r - origin_row(ly)) % 32) + 32) % 32;
    case (o / 2)
      0:       return dr * 32 + dc;
      1:       return (31 - dc) * 32 + dr;
      2:       return (31 - dr) * 32 + (31 - dc);
      default: return dc * 32 + (31 - dr);
    endcase
  endfunction

  function automatic bit ref_window(input int c, input int r, input int lx, input int ly);
    int c0, r0;
    c0 = origin_col(lx);
    r0 = origin_row(ly);
    return (c >= c0) && (c <= c0 + 31) && (r >= r0) && (r <= r0 + 31);
  endfunction

  // One raster clock: check outputs, present a pixel, predict its result, advance the model.
  task automatic apply_stimulus(input int c, input int r, input logic h);
    int a;
    logic [11:0] col;
    check_output("burst", burst, phase == 1);
    check_output("tank_reset", tank_reset, phase == 2);
    check_output("guarded", guarded, phase == 3);
    if (e2_valid) begin
      check_output("icon", icon, e2_icon);
      check_output("icon_c", icon_c, e2_col);
    end
    pixel_column = 12'(c);
    pixel_row    = 12'(r);
    hit          = h;
    #1;
    a = ref_addr(c, r, loc_x, loc_y, orient);
    check_output("tank_addr", rom.tank_addr, a);
    check_output("boom_addr", rom.boom_addr, a);
    col = (phase == 1) ? boom_rom[a] : 12'(palette[tank_rom[a]]);
    e2_valid = e1_valid;
    e2_icon  = e1_icon;
    e2_col   = e1_col;
    e1_valid = 1'b1;
    e1_icon  = ref_window(c, r, loc_x, loc_y) && (col != 12'hFFF);
    e1_col   = col;
    @(posedge clk);
    if (phase == 0) begin
      if (h) begin
        phase = 1;
        left  = BURST_N;
      end
    end else begin
      left--;
      if (left == 0) begin
        case (phase)
          1:       begin phase = 2; left = RESPAWN_N; end
          2:       begin phase = 3; left = GUARD_N; end
          default: begin phase = 0; left = 0; end
        endcase
      end
    end
    @(negedge clk);
  endtask

  task automatic random_step(input logic h);
    int c0, r0;
    c0 = origin_col(loc_x);
    r0 = origin_row(loc_y);
    apply_stimulus(c0 + $urandom_range(0, 39) - 4, r0 + $urandom_range(0, 39) - 4, h);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tank_rom[i] = 2'($urandom_range(0, 3));
      boom_rom[i] = 12'($urandom);
    end
    reset        = 1'b0;
    pixel_column = '0;
    pixel_row    = '0;
    loc_x        = '0;
    loc_y        = '0;
    orient       = '0;
    hit          = 1'b0;
    #2;
    check_output("rst_icon", icon, 0);
    check_output("rst_icon_c", icon_c, 0);
    check_output("rst_burst", burst, 0);
    check_output("rst_tank_reset", tank_reset, 0);
    check_output("rst_guarded", guarded, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");

    loc_x = 8'd10;
    loc_y = 8'd20;
    orient = 3'd0;
    tank_rom[0] = 2'd1;
    for (int c = 76; c <= 79; c++) apply_stimulus(c, 120, 1'b0);
    apply_stimulus(80, 120, 1'b0);
    check_output("origin_addr", rom.tank_addr, 0);
    apply_stimulus(81, 120, 1'b0);
    apply_stimulus(82, 120, 1'b0);
    check_output("origin_icon", icon, 1);
    check_output("origin_icon_c", icon_c, 12'h000);
    for (int c = 83; c <= 116; c++) apply_stimulus(c, 120, 1'b0);

    orient = 3'd2;
    apply_stimulus(80, 120, 1'b0);
    check_output("east_addr", rom.tank_addr, 992);
    orient = 3'd3;
    apply_stimulus(80, 120, 1'b0);
    check_output("southeast_addr", rom.tank_addr, 992);

    orient = 3'd0;
    tank_rom[0] = 2'd0;
    apply_stimulus(80, 120, 1'b0);
    apply_stimulus(10, 10, 1'b0);
    apply_stimulus(10, 10, 1'b0);
    check_output("transparent_icon", icon, 0);
    check_output("transparent_icon_c", icon_c, 12'hFFF);

    for (int i = 0; i < 40; i++) begin
      orient = 3'($urandom_range(0, 7));
      random_step(1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      loc_x = 8'($urandom_range(1, 255));
      loc_y = 8'($urandom_range(1, 255));
      for (int i = 0; i < 15; i++) begin
        orient = 3'($urandom_range(0, 7));
        random_step(1'b0);
      end
    end

    $display("[TB] lifecycle with mid-burst hit");
    random_step(1'b1);
    for (int i = 0; i < 24; i++) random_step(i == 3);

    $display("[TB] hit held high");
    for (int i = 0; i < 25; i++) random_step(1'b1);
    for (int i = 0; i < 20; i++) random_step(1'b0);

    $display("[TB] reset during respawn");
    random_step(1'b1);
    for (int i = 0; i < 20 && phase != 2; i++) random_step(1'b0);
    check_output("reached_respawn", phase == 2, 1);
    random_step(1'b0);
    reset = 1'b0;
    #1;
    check_output("mid_rst_tank_reset", tank_reset, 0);
    check_output("mid_rst_burst", burst, 0);
    check_output("mid_rst_guarded", guarded, 0);
    check_output("mid_rst_icon", icon, 0);
    @(negedge clk);
    phase    = 0;
    left     = 0;
    e1_valid = 1'b0;
    e2_valid = 1'b0;
    reset    = 1'b1;
    random_step(1'b0);
    random_step(1'b1);
    for (int i = 0; i < 22; i++) random_step(1'b0);
    random_step(1'b0);
    random_step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
Parametrised successor to the single-tank icon renderer. Maps a robot's map location and heading onto the display raster and drives the sprite ROMs. Pipelines the ROM read so that the pixel flag and colour are timing-aligned with the display timing generator. Owns the hit → burst → respawn → guard lifecycle, with programmable durations.

Parameters:
ICON_LOG2, 5, sprite edge is 2**ICON_LOG2 pixels (default 32x32).
COLOR_W, 12, RGB colour width.
X_SHIFT, 3, display column = loc_x << X_SHIFT.
Y_MUL, 6, display row = loc_y * Y_MUL.
BURST_CYCLES, 32'h2FFFFFF, length of the explosion phase in clocks.
RESPAWN_CYCLES, 16, length of the tank_reset pulse in clocks.
GUARD_CYCLES, 32'h1FFFFFF, length of post-respawn invulnerability in clocks.
TRANSPARENT, 12'hFFF, colour treated as see-through.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_column  in  12  current raster column from dtg
pixel_row  in  12  current raster row from dtg
loc_x  in  8  robot X in the 128x128 map
loc_y  in  8  robot Y in the 128x128 map
orient  in  3  BotInfo heading; 0=N, 2=E, 4=S, 6=W; odd values are diagonals
hit  in  1  single-cycle or level hit strobe
tank_addr  out  2*ICON_LOG2  address to the 2-bit body ROM
tank_data  in  2  body ROM data, 1-cycle read latency
boom_addr  out  2*ICON_LOG2  address to the explosion ROM
boom_data  in  COLOR_W  explosion ROM data, 1-cycle read latency
icon  out  1  pixel is opaque sprite
icon_c  out  COLOR_W  sprite colour
burst  out  1  explosion phase active
tank_reset  out  1  respawn pulse to the robot model
guarded  out  1  invulnerability phase active

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=ALIVE, counter=0, pipeline valid bits 0.
- Origin: col0 = loc_x << X_SHIFT and row0 = loc_y * Y_MUL, both computed at 12 bits. Window is col0 ≤ pixel_column ≤ col0+2**ICON_LOG2−1, same rule for rows. Window sums are computed at 13 bits, so a sprite near the screen edge clips rather than wrapping.
- Stage 0 (register): in-window bit, plus address from dr = pixel_row−row0 and dc = pixel_column−col0 (each ICON_LOG2 bits).
  - N: {dr, dc}
  - E: {~dc, dr}
  - S: {~dr, ~dc}
  - W: {dc, ~dr}
- Diagonal headings (odd orient) use the cardinal orient & 3'b110 (NE→N, SE→E, SW→S, NW→W).
- Both ROM addresses are driven with the same stage-0 address.
- Stage 1: the ROM read occurs; the window bit and a burst snapshot are delayed to match.
- Stage 2 (register): select colour.
  - Snapshot burst=1: colour is boom_data.
  - Otherwise tank_data is mapped through the palette: 0→FFF, 1→000, 2→00F, 3→025, zero-extended/truncated to COLOR_W.
  - icon = window & (colour ≠ TRANSPARENT).
  - icon_c is always updated, even when icon=0.
- Total latency is 2 clocks from a pixel coordinate to icon/icon_c. The burst snapshot guarantees that no pixel mixes the two ROMs mid-pipeline.
- Lifecycle FSM:
  - ALIVE: on hit → BURST, counter cleared.
  - BURST: burst=1; when counter reaches BURST_CYCLES−1 → RESPAWN, counter cleared.
  - RESPAWN: tank_reset=1 for exactly RESPAWN_CYCLES clocks → GUARD.
  - GUARD: guarded=1 for GUARD_CYCLES clocks → ALIVE.
- hit is ignored in BURST, RESPAWN and GUARD; it does not restart the burst.
- hit held high is level-sensitive only in ALIVE: re-entry happens on the first ALIVE cycle in which hit=1.
- Counter is 32-bit, saturation-free, and cleared on every state change.
- Reset asserted mid-lifecycle returns the FSM to ALIVE immediately; tank_reset drops asynchronously.

Optional Feature:
SPRITE_BLINK_EN
- Defined: during GUARD, icon is forced to 0 whenever counter bit 22 = 1, giving a visible blink.
- Undefined: the sprite is rendered normally during GUARD.
- guarded is present in both builds.

Decomposition:
- sprite_pkg: state enum (ALIVE, BURST, RESPAWN, GUARD), palette constant array, orientation codes.
- One sub-module, sprite_lifecycle_fsm: FSM plus counter, outputs burst/tank_reset/guarded. The address and colour pipeline stays in the top level.

Test Plan:
- loc=(10,20), orient=0, raster scan → icon first asserts 2 clocks after pixel_column=80, pixel_row=120; tank_addr=0 there; tank_data=1 gives icon_c=000, icon=1.
- orient=2 at dr=0, dc=0 → tank_addr={5'd31, 5'd0}; orient=3 gives the identical address.
- tank_data=0 → icon=0 with icon_c=FFF; pixel outside the window → icon=0 regardless of ROM data.
- BURST_CYCLES=8, RESPAWN_CYCLES=4, GUARD_CYCLES=6: hit pulse → burst high for 8 clocks, tank_reset high for 4, guarded for 6, then ALIVE. A second hit during burst changes nothing.
- burst toggles mid-scan → each output pixel carries the colour of the ROM selected at its stage-0 snapshot.
- reset=0 during RESPAWN → tank_reset, burst, guarded, icon all 0 in the same cycle; after release, a hit restarts BURST from count 0.
